// File: rtl/eq_seq_pkg.sv
// Shared encodings for the band tap sequencer: count modes and controller state.
package eq_seq_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP_UP   = 2'd0,
        MODE_WRAP_DOWN = 2'd1,
        MODE_BOUNCE    = 2'd2,
        MODE_RSVD      = 2'd3
    } mode_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/band_tap_sequencer.sv
// Generates the (channel, tap) index stream for the time-multiplexed filter bank,
// with runtime-loadable bounds, three count modes and start/stop/repeat control.
module band_tap_sequencer
    import eq_seq_pkg::*;
#(
    parameter int TAP_MIN  = 0,
    parameter int TAP_MAX  = 63,
    parameter int NUM_CH   = 8,
    parameter int MODE_DEF = 0,
    localparam int TW = $clog2(TAP_MAX + 1),
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clk_enable,
    input  logic          start,
    input  logic          stop,
    input  logic          repeat_en,
    input  logic          cfg_load,
    input  logic [TW-1:0] cfg_min,
    input  logic [TW-1:0] cfg_max,
    input  logic [1:0]    cfg_mode,
    output logic [TW-1:0] tap_idx,
    output logic [CW-1:0] ch_idx,
    output logic          busy,
    output logic          dir_down,
    output logic          phase_min,
    output logic          phase_max,
    output logic          ch_last,
    output logic          frame_done,
    output logic          cfg_err
);

    typedef struct packed {
        logic [TW-1:0] tap;
        logic          dir_down;
        logic          ch_step;
    } step_t;

    // One counted step; clamps at the active bounds so the index never wraps through 0/2^TW.
    function automatic step_t next_step(input logic [TW-1:0] tap, input logic dn,
                                        input logic [TW-1:0] lo, input logic [TW-1:0] hi,
                                        input mode_t mode);
        step_t s;
        s.tap      = tap;
        s.dir_down = dn;
        s.ch_step  = 1'b0;
        case (mode)
            MODE_WRAP_DOWN: begin
                s.dir_down = 1'b1;
                if (tap <= lo) begin
                    s.tap     = hi;
                    s.ch_step = 1'b1;
                end else begin
                    s.tap = tap - 1'b1;
                end
            end
            MODE_BOUNCE: begin
                if (lo == hi) begin
                    s.dir_down = 1'b0;
                    s.ch_step  = 1'b1;
                end else if (dn) begin
                    s.tap = (tap > lo) ? tap - 1'b1 : lo;
                    if (s.tap == lo) begin
                        s.dir_down = 1'b0;
                        s.ch_step  = 1'b1;
                    end
                end else begin
                    s.tap      = (tap < hi) ? tap + 1'b1 : hi;
                    s.dir_down = (s.tap == hi);
                end
            end
            default: begin
                s.dir_down = 1'b0;
                if (tap >= hi) begin
                    s.tap     = lo;
                    s.ch_step = 1'b1;
                end else begin
                    s.tap = tap + 1'b1;
                end
            end
        endcase
        return s;
    endfunction

    state_t        state;
    logic [TW-1:0] act_min, act_max;
    mode_t         act_mode;

    logic          cfg_ok, load_ok, step_en;
    logic [TW-1:0] eff_min, eff_max;
    mode_t         eff_mode;
    logic [TW-1:0] entry_tap;
    logic          entry_dn;
    step_t         nx;

    assign cfg_ok  = (cfg_min <= cfg_max) && (cfg_mode != 2'd3);
    assign load_ok = (state == ST_IDLE) && cfg_load && cfg_ok;
    assign step_en = (state == ST_RUN) && clk_enable;
    assign nx      = next_step(tap_idx, dir_down, act_min, act_max, act_mode);

    // A load coinciding with start takes effect for the frame being started.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        eff_min   = act_min;
        eff_max   = act_max;
        eff_mode  = act_mode;
        if (load_ok) begin
            eff_min  = cfg_min;
            eff_max  = cfg_max;
            eff_mode = mode_t'(cfg_mode);
        end
        entry_dn  = (eff_mode == MODE_WRAP_DOWN);
        entry_tap = entry_dn ? eff_max : eff_min;
    end

    assign busy      = (state == ST_RUN);
    assign phase_min = step_en && (tap_idx == act_min);
    assign phase_max = step_en && (tap_idx == act_max);
    assign ch_last   = step_en && nx.ch_step;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            tap_idx    <= TW'(TAP_MIN);
            ch_idx     <= '0;
            dir_down   <= 1'b0;
            frame_done <= 1'b0;
            cfg_err    <= 1'b0;
            act_min    <= TW'(TAP_MIN);
            act_max    <= TW'(TAP_MAX);
            act_mode   <= mode_t'(MODE_DEF[1:0]);
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
            frame_done <= 1'b0;
            cfg_err    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cfg_load) begin
                        if (cfg_ok) begin
                            act_min  <= cfg_min;
                            act_max  <= cfg_max;
                            act_mode <= mode_t'(cfg_mode);
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                    if (start) begin
                        state    <= ST_RUN;
                        ch_idx   <= '0;
                        tap_idx  <= entry_tap;
                        dir_down <= entry_dn;
                    end
                end
                default: begin
                    if (stop) begin
                        state <= ST_IDLE;
                    end else if (clk_enable) begin
                        tap_idx  <= nx.tap;
                        dir_down <= nx.dir_down;
                        if (nx.ch_step) begin
                            if (ch_idx == CW'(NUM_CH - 1)) begin
                                ch_idx     <= '0;
                                frame_done <= 1'b1;
                                if (repeat_en) begin
                                    tap_idx  <= entry_tap;
                                    dir_down <= entry_dn;
                                end else begin
                                    state <= ST_IDLE;
                                end
                            end else begin
                                ch_idx <= ch_idx + 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/band_tap_sequencer.md
Name: band_tap_sequencer

Overview:
Parametrised successor to the single-range tap counter. Generates the (channel, tap) index stream that drives the time-multiplexed 8-band filter datapath. Runtime-loadable bounds, three count modes, an outer channel counter, start/stop/repeat control and a frame-done pulse. Sits between the sample-rate strobe generator and the coefficient ROM / MAC address logic.

Parameters:
TAP_MIN, 0, reset/default lower tap bound.
TAP_MAX, 63, reset/default upper tap bound; also sizes counter.
NUM_CH, 8, channels (bands) per frame, >=1.
MODE_DEF, 0, reset/default count mode.
TW, $clog2(TAP_MAX+1), tap index width (derived, not overridden).
CW, (NUM_CH>1)?$clog2(NUM_CH):1, channel index width (derived).

Ports:
clk  in  1  clock.
rst  in  1  asynchronous, active-high reset.
clk_enable  in  1  step strobe; counters advance only when high.
start  in  1  begin frame (honoured in IDLE only).
stop  in  1  abort frame (honoured in RUN only).
repeat_en  in  1  at frame end: 1 = restart immediately, 0 = return to IDLE.
cfg_load  in  1  latch cfg_* (honoured in IDLE only).
cfg_min  in  TW  new lower bound.
cfg_max  in  TW  new upper bound.
cfg_mode  in  2  0 = wrap-up, 1 = wrap-down, 2 = bounce, 3 = reserved.
tap_idx  out  TW  current tap index (registered).
ch_idx  out  CW  current channel index (registered).
busy  out  1  high in RUN.
dir_down  out  1  current direction (registered).
phase_min  out  1  comb: busy & clk_enable & tap_idx==act_min.
phase_max  out  1  comb: busy & clk_enable & tap_idx==act_max.
ch_last  out  1  comb: busy & clk_enable & final step of current channel.
frame_done  out  1  registered one-cycle pulse after final step of frame.
cfg_err  out  1  registered one-cycle pulse on rejected cfg_load.

Behaviour:
- Reset: state IDLE; tap_idx=TAP_MIN; ch_idx=0; dir_down=0; busy=0; frame_done=0; cfg_err=0; act_min=TAP_MIN, act_max=TAP_MAX, act_mode=MODE_DEF. Reset mid-frame aborts immediately, no frame_done.
- States: IDLE, RUN. IDLE->RUN on start; RUN->IDLE on stop, or on frame end with repeat_en=0.
- Entering RUN (start, or repeat at frame end): ch_idx=0; tap_idx=act_max and dir_down=1 in wrap-down mode, else tap_idx=act_min and dir_down=0. start/stop/clk_enable take effect on the same edge; the first counted step follows the next clk_enable.
- RUN step (clk_enable=1 only):
  - Wrap-up: tap+1; at act_max -> act_min, channel step.
  - Wrap-down: tap-1; at act_min -> act_max, channel step.
  - Bounce: up to act_max, flip, down to act_min, flip; endpoints are not repeated (e.g. 0,1,2,3,2,1,0). Channel step on reaching act_min while descending, restarting upward. If act_min==act_max, every step is a channel step.
- Channel step: ch_idx+1. At ch_idx==NUM_CH-1 the step is the frame end: frame_done pulses the next cycle, ch_idx=0, and RUN continues or goes to IDLE per repeat_en.
- stop in RUN: to IDLE at next edge, tap_idx/ch_idx hold; stop beats a coincident final step (no frame_done). start in RUN is ignored; stop in IDLE is ignored.
- cfg_load in IDLE: if cfg_min<=cfg_max and cfg_mode!=3, latch bounds and mode; else cfg_err pulses and config is unchanged. cfg_load in RUN is ignored silently, no cfg_err. cfg_load together with start: config is latched first and used for the starting frame.
- Arithmetic is unsigned TW-bit; never exceed act bounds; no wrap through 0/2^TW.
- Combinational outputs are 0 whenever busy=0.

Decomposition:
- Package eq_seq_pkg: mode encodings (MODE_WRAP_UP=0, MODE_WRAP_DOWN=1, MODE_BOUNCE=2) and state encoding.
- No sub-module. A single module with a next-index function is sufficient.

Test Plan:
- Defaults MIN=0, MAX=3, NUM_CH=2, mode 0, clk_enable=1, start -> tap 0,1,2,3,0,1,2,3; ch 0x4 then 1x4; frame_done one cycle after the 8th step; busy falls.
- cfg_load min=1, max=3, mode 2, then start -> tap 1,2,3,2,1 then ch=1; dir_down toggles at 3 and at 1.
- cfg_load min=5, max=2 -> cfg_err one pulse; next frame still uses 0..3.
- repeat_en=1 across frame end -> frame_done pulse, busy stays 1, ch returns to 0, no idle gap.
- clk_enable toggled 1/0 -> index advances only on enabled cycles; phase_min/phase_max are 0 while clk_enable=0.
- stop coincident with final step -> IDLE, no frame_done; async rst mid-frame -> all outputs at reset values immediately.
